// File: rtl/adder_with_tap.sv
// adder_with_tap: 4-bit ripple-carry adder behind an IEEE 1149.1-style TAP.
// Holds the adder core, a 14-cell boundary-scan register on the adder pins,
// a 3-bit instruction register, a 1-bit bypass register and the 16-state
// TAP controller. TMS and TDI rely on pad-level weak pull-ups.
module adder_with_tap #(
    parameter int size         = 4,
    parameter int BSC_Reg_size = 14,
    parameter int IR_Reg_size  = 3
) (
    input  logic            TCK,
    input  logic            TRST_n,
    input  logic            TMS,
    input  logic            TDI,
    output logic            TDO,
    input  logic [size-1:0] a,
    input  logic [size-1:0] b,
    input  logic            c_in,
    output logic [size-1:0] sum,
    output logic            c_out
);

    // TAP controller states; the encoding is fixed so the state is easy to probe
    typedef enum logic [3:0] {
        ST_TLR    = 4'd0,
        ST_RTI    = 4'd1,
        ST_SEL_DR = 4'd2,
        ST_CAP_DR = 4'd3,
        ST_SH_DR  = 4'd4,
        ST_EX1_DR = 4'd5,
        ST_PAU_DR = 4'd6,
        ST_EX2_DR = 4'd7,
        ST_UPD_DR = 4'd8,
        ST_SEL_IR = 4'd9,
        ST_CAP_IR = 4'd10,
        ST_SH_IR  = 4'd11,
        ST_EX1_IR = 4'd12,
        ST_PAU_IR = 4'd13,
        ST_EX2_IR = 4'd14,
        ST_UPD_IR = 4'd15
    } tap_state_t;

    localparam logic [IR_Reg_size-1:0] IR_EXTEST  = 3'b000;
    localparam logic [IR_Reg_size-1:0] IR_SAMPLE  = 3'b010;
    localparam logic [IR_Reg_size-1:0] IR_INTEST  = 3'b011;
    localparam logic [IR_Reg_size-1:0] IR_BYPASS  = 3'b111;
    localparam logic [IR_Reg_size-1:0] IR_CAPTURE = 3'b001;

    tap_state_t state_r;
    tap_state_t state_next_s;

    logic [IR_Reg_size-1:0]  ir_shift_r;
    logic [IR_Reg_size-1:0]  ir_r;
    logic [BSC_Reg_size-1:0] bsr_cap_r;
    logic [BSC_Reg_size-1:0] bsr_upd_r;
    logic                    bypass_r;
    logic                    tdo_r;
    logic                    enableTDO;

    logic                    bsr_sel_s;
    logic                    intest_s;
    logic                    extest_s;
    logic                    shift_dr_s;
    logic                    shift_ir_s;

    logic [size-1:0]         a_core_s;
    logic [size-1:0]         b_core_s;
    logic                    c_in_core_s;
    logic [size-1:0]         sum_core_s;
    logic                    c_out_core_s;

    logic [BSC_Reg_size-1:0] BSC_Interface;
    logic [BSC_Reg_size-1:0] bsr_capture_s;

    // One full-adder bit: returns {carry_out, sum}
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        full_add = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    // Instruction decode; undefined codes, RUNBIST and IDCODE fall to bypass
    always_comb begin
        intest_s   = (ir_r == IR_INTEST);
        extest_s   = (ir_r == IR_EXTEST);
        bsr_sel_s  = (ir_r == IR_EXTEST) || (ir_r == IR_SAMPLE) || (ir_r == IR_INTEST);
        shift_dr_s = (state_r == ST_SH_DR);
        shift_ir_s = (state_r == ST_SH_IR);
    end

    // Core input mux: update latches drive the core only under INTEST
    always_comb begin
        if (intest_s) begin
            a_core_s    = bsr_upd_r[8:5];
            b_core_s    = bsr_upd_r[4:1];
            c_in_core_s = bsr_upd_r[0];
        end else begin
            a_core_s    = a;
            b_core_s    = b;
            c_in_core_s = c_in;
        end
    end

    // Ripple-carry adder core, one full adder per bit
    always_comb begin : ripple_chain
        logic [size:0] carry_v;
        carry_v    = {(size+1){1'b0}};
        sum_core_s = {size{1'b0}};
        carry_v[0] = c_in_core_s;
        for (int i = 0; i < size; i++) begin
            {carry_v[i+1], sum_core_s[i]} = full_add(a_core_s[i], b_core_s[i], carry_v[i]);
        end
        c_out_core_s = carry_v[size];
    end

    // Pin output mux: update latches drive the pins only under EXTEST
    always_comb begin
        if (extest_s) begin
            sum   = bsr_upd_r[13:10];
            c_out = bsr_upd_r[9];
        end else begin
            sum   = sum_core_s;
            c_out = c_out_core_s;
        end
    end

    // Observation vectors: core view for probing, capture view mixes pins and core results
    always_comb begin
        BSC_Interface = {sum_core_s, c_out_core_s, a_core_s, b_core_s, c_in_core_s};
        bsr_capture_s = {sum_core_s, c_out_core_s, a, b, c_in};
    end

    // TAP next-state logic on TMS
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_TLR:    state_next_s = TMS ? ST_TLR    : ST_RTI;
            ST_RTI:    state_next_s = TMS ? ST_SEL_DR : ST_RTI;
            ST_SEL_DR: state_next_s = TMS ? ST_SEL_IR : ST_CAP_DR;
            ST_CAP_DR: state_next_s = TMS ? ST_EX1_DR : ST_SH_DR;
            ST_SH_DR:  state_next_s = TMS ? ST_EX1_DR : ST_SH_DR;
            ST_EX1_DR: state_next_s = TMS ? ST_UPD_DR : ST_PAU_DR;
            ST_PAU_DR: state_next_s = TMS ? ST_EX2_DR : ST_PAU_DR;
            ST_EX2_DR: state_next_s = TMS ? ST_UPD_DR : ST_SH_DR;
            ST_UPD_DR: state_next_s = TMS ? ST_SEL_DR : ST_RTI;
            ST_SEL_IR: state_next_s = TMS ? ST_TLR    : ST_CAP_IR;
            ST_CAP_IR: state_next_s = TMS ? ST_EX1_IR : ST_SH_IR;
            ST_SH_IR:  state_next_s = TMS ? ST_EX1_IR : ST_SH_IR;
            ST_EX1_IR: state_next_s = TMS ? ST_UPD_IR : ST_PAU_IR;
            ST_PAU_IR: state_next_s = TMS ? ST_EX2_IR : ST_PAU_IR;
            ST_EX2_IR: state_next_s = TMS ? ST_UPD_IR : ST_SH_IR;
            ST_UPD_IR: state_next_s = TMS ? ST_SEL_DR : ST_RTI;
            default:   state_next_s = ST_TLR;
        endcase
    end

    // TAP state register
    always_ff @(posedge TCK) begin
        if (!TRST_n) begin
            state_r <= ST_TLR;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Capture and shift stages; only the Capture and Shift states touch them
    always_ff @(posedge TCK) begin
        if (!TRST_n) begin
            ir_shift_r <= {IR_Reg_size{1'b0}};
            bsr_cap_r  <= {BSC_Reg_size{1'b0}};
            bypass_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_CAP_DR: begin
                    if (bsr_sel_s) begin
                        bsr_cap_r <= bsr_capture_s;
                    end else begin
                        bypass_r <= 1'b0;
                    end
                end
                ST_SH_DR: begin
                    if (bsr_sel_s) begin
                        bsr_cap_r <= {TDI, bsr_cap_r[BSC_Reg_size-1:1]};
                    end else begin
                        bypass_r <= TDI;
                    end
                end
                ST_CAP_IR: ir_shift_r <= IR_CAPTURE;
                ST_SH_IR:  ir_shift_r <= {TDI, ir_shift_r[IR_Reg_size-1:1]};
                default: begin
                    ir_shift_r <= ir_shift_r;
                    bsr_cap_r  <= bsr_cap_r;
                    bypass_r   <= bypass_r;
                end
            endcase
        end
    end

    // Update latches: active IR and BSR update cells change on the falling edge
    always_ff @(negedge TCK) begin
        if (!TRST_n) begin
            ir_r      <= IR_BYPASS;
            bsr_upd_r <= {BSC_Reg_size{1'b0}};
        end else if (state_r == ST_TLR) begin
            ir_r <= IR_BYPASS;
        end else begin
            if (state_r == ST_UPD_IR) begin
                ir_r <= ir_shift_r;
            end
            if ((state_r == ST_UPD_DR) && bsr_sel_s) begin
                bsr_upd_r <= bsr_cap_r;
            end
        end
    end

    // TDO and its enable are launched on the falling edge from the selected stage LSB
    always_ff @(negedge TCK) begin
        if (!TRST_n) begin
            enableTDO <= 1'b0;
            tdo_r     <= 1'b0;
        end else begin
            enableTDO <= shift_dr_s || shift_ir_s;
            if (shift_ir_s) begin
                tdo_r <= ir_shift_r[0];
            end else if (bsr_sel_s) begin
                tdo_r <= bsr_cap_r[0];
            end else begin
                tdo_r <= bypass_r;
            end
        end
    end

    assign TDO = enableTDO ? tdo_r : 1'bz;

endmodule

// File: tb/tb_adder_with_tap.sv
// Self-checking bench for adder_with_tap: vector table for the adder path,
// hand-written TAP sequences for bypass, INTEST, EXTEST, SAMPLE_PRELOAD, resets.
module tb_adder_with_tap;

    logic       tck;
    logic       trst_n;
    logic       tms_drv, tms_oe;
    logic       tdi_drv, tdi_oe;
    logic [3:0] a, b;
    logic       c_in;
    wire  [3:0] sum;
    wire        c_out;
    wire        tdo;

    // Board-level weak pull-ups on TMS and TDI
    wire tms_pin = tms_oe ? tms_drv : 1'b1;
    wire tdi_pin = tdi_oe ? tdi_drv : 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    adder_with_tap u_dut (
        .TCK    (tck),
        .TRST_n (trst_n),
        .TMS    (tms_pin),
        .TDI    (tdi_pin),
        .TDO    (tdo),
        .a      (a),
        .b      (b),
        .c_in   (c_in),
        .sum    (sum),
        .c_out  (c_out)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       c_in;
        logic [3:0] sum;
        logic       c_out;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One TCK cycle: drive TMS/TDI, pass the rising edge, return just after the falling edge
    task automatic tick(input logic tms_v, input logic tdi_v);
        tms_drv = tms_v;
        tdi_drv = tdi_v;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    // From Run-Test/Idle: load an IR code, return what the IR capture shifted out
    task automatic load_ir(input logic [2:0] code, output logic [2:0] cap);
        cap = 3'b000;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        cap[0] = tdo;
        for (int i = 0; i < 3; i++) begin
            tick(i == 2, code[i]);
            if (i < 2) cap[i+1] = tdo;
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    // From Run-Test/Idle: capture, shift n bits LSB first, update, back to idle
    task automatic scan_dr(input logic [13:0] din, input int n, output logic [13:0] dout);
        dout = 14'h0;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        dout[0] = tdo;
        for (int i = 0; i < n; i++) begin
            tick(i == n - 1, din[i]);
            if (i < n - 1) dout[i+1] = tdo;
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    logic [2:0]  ir_cap;
    logic [13:0] dout;
    logic [13:0] bsr_before;
    logic [9:0]  byp_bits;

    initial begin
        vecs[0] = '{4'hA, 4'h5, 1'b0, 4'hF, 1'b0};
        vecs[1] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0};
        vecs[2] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
        vecs[3] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1};
        vecs[4] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1};
        vecs[5] = '{4'h7, 4'h1, 1'b0, 4'h8, 1'b0};
        vecs[6] = '{4'h3, 4'hC, 1'b1, 4'h0, 1'b1};
        vecs[7] = '{4'h6, 4'h9, 1'b0, 4'hF, 1'b0};

        tms_oe = 1'b1; tdi_oe = 1'b1;
        tms_drv = 1'b1; tdi_drv = 1'b1;
        a = 4'h9; b = 4'h6; c_in = 1'b1;

        // Hardware reset
        trst_n = 1'b0;
        tick(1'b1, 1'b1);
        chk("rst_state", 32'(u_dut.state_r), 32'd0);
        chk("rst_ir", u_dut.ir_r, 3'b111);
        chk("rst_bsr_cap", u_dut.bsr_cap_r, 14'h0);
        chk("rst_bsr_upd", u_dut.bsr_upd_r, 14'h0);
        chk("rst_bypass", u_dut.bypass_r, 1'b0);
        chk("rst_en_tdo", u_dut.enableTDO, 1'b0);
        chk("rst_bsc_in", u_dut.BSC_Interface[8:0], {4'h9, 4'h6, 1'b1});
        trst_n = 1'b1;
        tick(1'b0, 1'b0);
        chk("idle_state", 32'(u_dut.state_r), 32'd1);

        // Normal-mode adder vectors
        for (int i = 0; i < 8; i++) begin
            a = vecs[i].a; b = vecs[i].b; c_in = vecs[i].c_in;
            #1;
            chk($sformatf("vec%0d_sum", i), sum, vecs[i].sum);
            chk($sformatf("vec%0d_cout", i), c_out, vecs[i].c_out);
            chk($sformatf("vec%0d_core", i), u_dut.BSC_Interface[13:9], {vecs[i].sum, vecs[i].c_out});
        end

        // Bypass scan of 10 bits with a Pause-DR stay
        a = 4'h5; b = 4'h6; c_in = 1'b1;
        byp_bits = 10'b1011001101;
        bsr_before = u_dut.bsr_cap_r;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("byp_capture", tdo, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(i == 4, byp_bits[i]);
            if (i < 4) chk($sformatf("byp_bit%0d", i), tdo, byp_bits[i]);
        end
        tick(1'b0, 1'b0);
        chk("byp_pause_state", 32'(u_dut.state_r), 32'd6);
        chk("byp_pause_en", u_dut.enableTDO, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        chk("byp_bit4", tdo, byp_bits[4]);
        for (int i = 5; i < 10; i++) begin
            tick(i == 9, byp_bits[i]);
            if (i < 9) chk($sformatf("byp_bit%0d", i), tdo, byp_bits[i]);
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        chk("byp_ir_kept", u_dut.ir_r, 3'b111);
        chk("byp_bsr_kept", u_dut.bsr_cap_r, bsr_before);

        // Five TMS=1 clocks from Shift-DR reach Test-Logic-Reset
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("tms_rst_shift", 32'(u_dut.state_r), 32'd4);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        chk("tms_rst_tlr", 32'(u_dut.state_r), 32'd0);
        tick(1'b0, 1'b0);

        // Undriven TMS/TDI read as 1 and park the controller in Test-Logic-Reset
        tms_oe = 1'b0; tdi_oe = 1'b0;
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
        chk("pullup_tms", u_dut.TMS, 1'b1);
        chk("pullup_tdi", u_dut.TDI, 1'b1);
        chk("pullup_tlr", 32'(u_dut.state_r), 32'd0);
        tms_oe = 1'b1; tdi_oe = 1'b1;
        tick(1'b0, 1'b0);

        // INTEST: core driven from update latches
        load_ir(3'b011, ir_cap);
        chk("intest_ir_cap", ir_cap, 3'b001);
        chk("intest_ir", u_dut.ir_r, 3'b011);
        scan_dr(14'b0100_1_1010_1010_0, 14, dout);
        chk("intest_scan0_out", dout, {4'b0000, 1'b0, 4'h5, 4'h6, 1'b1});
        chk("intest_core", u_dut.BSC_Interface, 14'b0100_1_1010_1010_0);
        chk("intest_sum_pin", sum, 4'b0100);
        chk("intest_cout_pin", c_out, 1'b1);
        scan_dr({5'b00000, 4'hF, 4'hF, 1'b1}, 14, dout);
        chk("intest_scan1_out", dout, {4'b0100, 1'b1, 4'h5, 4'h6, 1'b1});
        chk("intest_core_ff", u_dut.BSC_Interface[13:9], 5'b1111_1);
        scan_dr({5'b00000, 4'hF, 4'hF, 1'b1}, 14, dout);
        chk("intest_scan2_out", dout[13:9], 5'b1111_1);

        // EXTEST: pins driven from update latches
        load_ir(3'b000, ir_cap);
        chk("extest_ir_cap", ir_cap, 3'b001);
        scan_dr({4'b1011, 1'b0, 9'h000}, 14, dout);
        chk("extest_scan_out", dout, {4'b1100, 1'b0, 4'h5, 4'h6, 1'b1});
        chk("extest_sum_pin", sum, 4'b1011);
        chk("extest_cout_pin", c_out, 1'b0);
        a = 4'hF; b = 4'hF; c_in = 1'b1;
        #1;
        chk("extest_sum_hold", sum, 4'b1011);
        chk("extest_cout_hold", c_out, 1'b0);
        chk("extest_core", u_dut.BSC_Interface[13:9], 5'b1111_1);

        // Test-Logic-Reset via TMS restores BYPASS and transparent pins
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        chk("tlr_ir", u_dut.ir_r, 3'b111);
        a = 4'h1; b = 4'h2; c_in = 1'b0;
        #1;
        chk("tlr_sum_pin", sum, 4'h3);
        chk("tlr_cout_pin", c_out, 1'b0);
        tick(1'b0, 1'b0);

        // SAMPLE_PRELOAD: observe pins without disturbing them
        a = 4'h3; b = 4'h4; c_in = 1'b1;
        load_ir(3'b010, ir_cap);
        chk("sample_ir", u_dut.ir_r, 3'b010);
        chk("sample_sum_pre", sum, 4'h8);
        scan_dr(14'h0000, 14, dout);
        chk("sample_in_cells", dout[8:0], 9'b0011_0100_1);
        chk("sample_out_cells", dout[13:9], 5'b1000_0);
        chk("sample_sum_post", sum, 4'h8);
        chk("sample_cout_post", c_out, 1'b0);
        scan_dr({4'b1011, 1'b0, 9'h1A5}, 14, dout);
        chk("sample_preload", u_dut.bsr_upd_r, {4'b1011, 1'b0, 9'h1A5});
        chk("sample_sum_transp", sum, 4'h8);

        // Hardware reset in mid-test clears the scan cells and forces BYPASS
        trst_n = 1'b0;
        tick(1'b0, 1'b0);
        chk("rst2_state", 32'(u_dut.state_r), 32'd0);
        chk("rst2_ir", u_dut.ir_r, 3'b111);
        chk("rst2_bsr_cap", u_dut.bsr_cap_r, 14'h0);
        chk("rst2_bsr_upd", u_dut.bsr_upd_r, 14'h0);
        trst_n = 1'b1;
        tick(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Run-time guard so the bench never hangs
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
